// File: rtl/retire_trace_buffer_if.sv
// ----------------------------------------------------------------------------
// retire_trace_buffer_if
// Word-serial trace stream between the retire trace buffer (master) and the
// host/UART bridge (slave).
//   out_data  : current stream word            (master -> slave)
//   out_valid : stream word available          (master -> slave)
//   out_ready : consumer accepts the word when out_valid && out_ready are
//               high at a rising edge          (slave -> master)
// ----------------------------------------------------------------------------
interface retire_trace_buffer_if;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/retire_trace_buffer.sv
// ----------------------------------------------------------------------------
// retire_trace_buffer
// Retire-trace capture for the multicycle CPU. Every PC change records one
// entry {pc_prev, inst_prev, wv, waddr, wdata} for the instruction that just
// completed. Entries sit in a FIFO and leave word-serially on the stream port:
// W0 = pc, W1 = inst, W2 = {wv, 26'b0, waddr}, W3 = wdata [, W4 = timestamp].
//
// Optional feature: define TRACE_TIMESTAMP_EN to store a 32-bit free-running
// cycle count per entry and stream it as a fifth word.
//
// Ports:
//   clk, reset     : CPU clock, asynchronous active-low reset
//   trace_en       : capture enable (PC tracking continues when low)
//   pc, inst       : CPU program counter and the instruction held for it
//   rf_we/rf_waddr/rf_wdata : register-file write port being observed
//   overflow       : sticky, set when an entry is dropped on a full FIFO
//   drop_count     : saturating count of dropped entries
//   clr_ovf        : synchronous clear of overflow and drop_count
//   level          : number of entries stored
//   strm           : stream master (out_data, out_valid, out_ready)
// ----------------------------------------------------------------------------
module retire_trace_buffer #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   trace_en,
    input  logic [31:0]            pc,
    input  logic [31:0]            inst,
    input  logic                   rf_we,
    input  logic [4:0]             rf_waddr,
    input  logic [31:0]            rf_wdata,
    output logic                   overflow,
    output logic [15:0]            drop_count,
    input  logic                   clr_ovf,
    output logic [$clog2(DEPTH):0] level,
    retire_trace_buffer_if.master  strm
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
`ifdef TRACE_TIMESTAMP_EN
    localparam logic [2:0] LAST_WORD = 3'd4;
`else
    localparam logic [2:0] LAST_WORD = 3'd3;
`endif

    // Saturating increment for the drop counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    // Retire detection / write tracking state
    logic        armed_q, armed_d;
    logic [31:0] pc_prev_q, pc_prev_d;
    logic [31:0] inst_prev_q, inst_prev_d;
    logic        wv_q, wv_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;

    // FIFO control state
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic [2:0]       word_cnt_q, word_cnt_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      drop_count_q, drop_count_d;

    // FIFO storage (no reset: contents are qualified by level)
    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] inst_mem  [DEPTH];
    logic        wv_mem    [DEPTH];
    logic [4:0]  waddr_mem [DEPTH];
    logic [31:0] wdata_mem [DEPTH];
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] ts_q, ts_d;
    logic [31:0] ts_mem    [DEPTH];
`endif

    logic        retire_s;
    logic        wr_hit_s;
    logic        ent_wv_s;
    logic [4:0]  ent_waddr_s;
    logic [31:0] ent_wdata_s;
    logic        valid_s;
    logic        full_s;
    logic        accept_s;
    logic        pop_s;
    logic        push_req_s;
    logic        push_s;
    logic        drop_s;
    logic [31:0] word_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic [IDX_W-1:0] rd_idx_s;

    // Retire detection, entry assembly and write-tracking next state
    always_comb begin
        retire_s    = armed_q && (pc != pc_prev_q);
        wr_hit_s    = rf_we && (rf_waddr != 5'd0);
        // A write in the retire cycle belongs to the finishing instruction.
        ent_wv_s    = wr_hit_s ? 1'b1     : wv_q;
        ent_waddr_s = wr_hit_s ? rf_waddr : waddr_q;
        ent_wdata_s = wr_hit_s ? rf_wdata : wdata_q;

        armed_d     = 1'b1;
        pc_prev_d   = pc_prev_q;
        inst_prev_d = inst_prev_q;
        if (!armed_q || retire_s) begin
            pc_prev_d   = pc;
            inst_prev_d = inst;
        end else begin
            pc_prev_d   = pc_prev_q;
            inst_prev_d = inst_prev_q;
        end

        wv_d    = wv_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        // Clear the whole record so a write-less entry streams W2 = 0.
        if (retire_s) begin
            wv_d    = 1'b0;
            waddr_d = 5'd0;
            wdata_d = 32'd0;
        end else if (wr_hit_s) begin
            wv_d    = 1'b1;
            waddr_d = rf_waddr;
            wdata_d = rf_wdata;
        end else begin
            wv_d    = wv_q;
            waddr_d = waddr_q;
            wdata_d = wdata_q;
        end
    end

    // FIFO push/pop/drop control and word counter next state
    always_comb begin
        wr_idx_s   = wr_ptr_q[IDX_W-1:0];
        rd_idx_s   = rd_ptr_q[IDX_W-1:0];
        valid_s    = (level_q != '0);
        full_s     = (level_q == DEPTH_P);
        accept_s   = valid_s && strm.out_ready;
        pop_s      = accept_s && (word_cnt_q == LAST_WORD);
        push_req_s = retire_s && trace_en;
        // A pop of the head's last word frees a slot for this cycle's push.
        push_s     = push_req_s && (!full_s || pop_s);
        drop_s     = push_req_s && full_s && !pop_s;

        wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        level_d = level_q;
        if (push_s && !pop_s) begin
            level_d = level_q + PTR_ONE;
        end else if (pop_s && !push_s) begin
            level_d = level_q - PTR_ONE;
        end else begin
            level_d = level_q;
        end

        word_cnt_d = word_cnt_q;
        if (pop_s) begin
            word_cnt_d = 3'd0;
        end else if (accept_s) begin
            word_cnt_d = word_cnt_q + 3'd1;
        end else begin
            word_cnt_d = word_cnt_q;
        end

        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        // Clear wins over a coincident drop.
        if (clr_ovf) begin
            overflow_d   = 1'b0;
            drop_count_d = 16'd0;
        end else if (drop_s) begin
            overflow_d   = 1'b1;
            drop_count_d = sat_inc16(drop_count_q);
        end else begin
            overflow_d   = overflow_q;
            drop_count_d = drop_count_q;
        end

`ifdef TRACE_TIMESTAMP_EN
        ts_d = ts_q + 32'd1;
`endif
    end

    // Stream word select from the head entry
    always_comb begin
        word_s = 32'd0;
        case (word_cnt_q)
            3'd0:    word_s = pc_mem[rd_idx_s];
            3'd1:    word_s = inst_mem[rd_idx_s];
            3'd2:    word_s = {wv_mem[rd_idx_s], 26'd0, waddr_mem[rd_idx_s]};
            3'd3:    word_s = wdata_mem[rd_idx_s];
`ifdef TRACE_TIMESTAMP_EN
            3'd4:    word_s = ts_mem[rd_idx_s];
`endif
            default: word_s = 32'd0;
        endcase
    end

    // Control and tracking registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed_q      <= 1'b0;
            pc_prev_q    <= 32'd0;
            inst_prev_q  <= 32'd0;
            wv_q         <= 1'b0;
            waddr_q      <= 5'd0;
            wdata_q      <= 32'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            word_cnt_q   <= 3'd0;
            overflow_q   <= 1'b0;
            drop_count_q <= 16'd0;
`ifdef TRACE_TIMESTAMP_EN
            ts_q         <= 32'd0;
`endif
        end else begin
            armed_q      <= armed_d;
            pc_prev_q    <= pc_prev_d;
            inst_prev_q  <= inst_prev_d;
            wv_q         <= wv_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            word_cnt_q   <= word_cnt_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
`ifdef TRACE_TIMESTAMP_EN
            ts_q         <= ts_d;
`endif
        end
    end

    // FIFO storage write on accepted push
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem[wr_idx_s]    <= pc_prev_q;
            inst_mem[wr_idx_s]  <= inst_prev_q;
            wv_mem[wr_idx_s]    <= ent_wv_s;
            waddr_mem[wr_idx_s] <= ent_waddr_s;
            wdata_mem[wr_idx_s] <= ent_wdata_s;
`ifdef TRACE_TIMESTAMP_EN
            ts_mem[wr_idx_s]    <= ts_q;
`endif
        end
    end

    // Gate with valid so the bus reads 0 whenever nothing is stored.
    assign strm.out_valid = valid_s;
    assign strm.out_data  = valid_s ? word_s : 32'd0;
    assign overflow       = overflow_q;
    assign drop_count     = drop_count_q;
    assign level          = level_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed testbench for retire_trace_buffer (default build, 4 words/entry).
module tb_retire_trace_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        trace_en;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        overflow;
    logic [15:0] drop_count;
    logic        clr_ovf;
    logic [4:0]  level;

    retire_trace_buffer_if sif ();

    retire_trace_buffer #(.DEPTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .trace_en   (trace_en),
        .pc         (pc),
        .inst       (inst),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .overflow   (overflow),
        .drop_count (drop_count),
        .clr_ovf    (clr_ovf),
        .level      (level),
        .strm       (sif)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Bench model of the last captured (pc, inst) pair
    logic [31:0] cur_pc;
    logic [31:0] cur_inst;
    logic [31:0] exp_pc   [20];
    logic [31:0] exp_inst [20];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire_to(input logic [31:0] p, input logic [31:0] i);
        pc   = p;
        inst = i;
        tick();
        cur_pc   = p;
        cur_inst = i;
    endtask

    // Collects one 4-word entry with out_ready held high; ok=0 on timeout.
    task automatic read_entry(output logic [31:0] w0, output logic [31:0] w1,
                              output logic [31:0] w2, output logic [31:0] w3,
                              output bit ok);
        logic [31:0] w [4];
        int n = 0;
        int guard = 0;
        for (int k = 0; k < 4; k++) w[k] = 32'd0;
        sif.out_ready = 1'b1;
        while (n < 4 && guard < 40) begin
            if (sif.out_valid) begin
                w[n] = sif.out_data;
                n++;
            end
            tick();
            guard++;
        end
        sif.out_ready = 1'b0;
        w0 = w[0]; w1 = w[1]; w2 = w[2]; w3 = w[3];
        ok = (n == 4);
    endtask

    task automatic test_reset();
        reset = 1'b0; trace_en = 1'b1; pc = 32'd0; inst = 32'd0;
        rf_we = 1'b0; rf_waddr = 5'd0; rf_wdata = 32'd0; clr_ovf = 1'b0;
        sif.out_ready = 1'b0;
        tick(); tick();
        n_cmp++; if (sif.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", sif.out_valid); end
        n_cmp++; if (sif.out_data !== 32'd0) begin n_fail++; $display("FAIL rst_data got %h want 0", sif.out_data); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %b want 0", overflow); end
        n_cmp++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL rst_drop got %0d want 0", drop_count); end
        n_cmp++; if (level !== 5'd0) begin n_fail++; $display("FAIL rst_level got %0d want 0", level); end
        // First cycle after reset: pc differs from the reset pc_prev, no entry.
        pc = 32'h00400000; inst = 32'h3C010000;
        reset = 1'b1;
        tick();
        cur_pc = pc; cur_inst = inst;
        n_cmp++; if (level !== 5'd0) begin n_fail++; $display("FAIL arm_level got %0d want 0", level); end
        n_cmp++; if (sif.out_valid !== 1'b0) begin n_fail++; $display("FAIL arm_valid got %b want 0", sif.out_valid); end
    endtask

    task automatic test_basic();
        logic [31:0] w0, w1, w2, w3;
        bit ok;
        rf_we = 1'b1; rf_waddr = 5'd1; rf_wdata = 32'h10010000;
        tick();
        rf_we = 1'b0;
        retire_to(32'h00400004, 32'h34210000);
        n_cmp++; if (level !== 5'd1) begin n_fail++; $display("FAIL basic_level1 got %0d want 1", level); end
        n_cmp++; if (sif.out_data !== 32'h00400000) begin n_fail++; $display("FAIL basic_latency got %h want 00400000", sif.out_data); end
        read_entry(w0, w1, w2, w3, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL basic_timeout got incomplete want 4 words"); end
        n_cmp++; if (w0 !== 32'h00400000) begin n_fail++; $display("FAIL basic_w0 got %h want 00400000", w0); end
        n_cmp++; if (w1 !== 32'h3C010000) begin n_fail++; $display("FAIL basic_w1 got %h want 3c010000", w1); end
        n_cmp++; if (w2 !== 32'h80000001) begin n_fail++; $display("FAIL basic_w2 got %h want 80000001", w2); end
        n_cmp++; if (w3 !== 32'h10010000) begin n_fail++; $display("FAIL basic_w3 got %h want 10010000", w3); end
        n_cmp++; if (level !== 5'd0) begin n_fail++; $display("FAIL basic_level0 got %0d want 0", level); end
    endtask

    task automatic test_no_write();
        logic [31:0] w0, w1, w2, w3;
        bit ok;
        rf_we = 1'b1; rf_waddr = 5'd0; rf_wdata = 32'h5;
        tick();
        rf_we = 1'b0;
        retire_to(32'h00400008, 32'h00000000);
        read_entry(w0, w1, w2, w3, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL nowr_timeout got incomplete want 4 words"); end
        n_cmp++; if (w0 !== 32'h00400004) begin n_fail++; $display("FAIL nowr_w0 got %h want 00400004", w0); end
        n_cmp++; if (w1 !== 32'h34210000) begin n_fail++; $display("FAIL nowr_w1 got %h want 34210000", w1); end
        n_cmp++; if (w2 !== 32'h00000000) begin n_fail++; $display("FAIL nowr_w2 got %h want 00000000", w2); end
    endtask

    task automatic test_last_write_wins();
        logic [31:0] w0, w1, w2, w3;
        bit ok;
        rf_we = 1'b1; rf_waddr = 5'd3; rf_wdata = 32'd7;
        tick();
        rf_waddr = 5'd4; rf_wdata = 32'd9;
        retire_to(32'h0040000C, 32'h00000000);
        rf_we = 1'b0;
        read_entry(w0, w1, w2, w3, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL lww_timeout got incomplete want 4 words"); end
        n_cmp++; if (w0 !== 32'h00400008) begin n_fail++; $display("FAIL lww_w0 got %h want 00400008", w0); end
        n_cmp++; if (w2 !== 32'h80000004) begin n_fail++; $display("FAIL lww_w2 got %h want 80000004", w2); end
        n_cmp++; if (w3 !== 32'h00000009) begin n_fail++; $display("FAIL lww_w3 got %h want 00000009", w3); end
    endtask

    // Overflow, clear, push-at-full-with-pop and in-order drain.
    task automatic test_overflow();
        logic [31:0] w0, w1, w2, w3;
        logic [31:0] new_pc, new_inst;
        bit ok;
        sif.out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            exp_pc[i]   = cur_pc;
            exp_inst[i] = cur_inst;
            retire_to(32'h00002000 + 32'(4 * i), 32'hA0000000 + 32'(i));
        end
        n_cmp++; if (level !== 5'd16) begin n_fail++; $display("FAIL ovf_level got %0d want 16", level); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
        n_cmp++; if (drop_count !== 16'd4) begin n_fail++; $display("FAIL ovf_drops got %0d want 4", drop_count); end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_flag got %b want 0", overflow); end
        n_cmp++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL clr_drops got %0d want 0", drop_count); end
        // Take W0..W2 of the head, then retire while W3 is accepted.
        sif.out_ready = 1'b1;
        n_cmp++; if (sif.out_data !== exp_pc[0]) begin n_fail++; $display("FAIL full_w0 got %h want %h", sif.out_data, exp_pc[0]); end
        tick();
        n_cmp++; if (sif.out_data !== exp_inst[0]) begin n_fail++; $display("FAIL full_w1 got %h want %h", sif.out_data, exp_inst[0]); end
        tick();
        n_cmp++; if (sif.out_data !== 32'd0) begin n_fail++; $display("FAIL full_w2 got %h want 0", sif.out_data); end
        tick();
        n_cmp++; if (sif.out_data !== 32'd0) begin n_fail++; $display("FAIL full_w3 got %h want 0", sif.out_data); end
        new_pc = cur_pc; new_inst = cur_inst;
        retire_to(32'h00003000, 32'hB0000000);
        sif.out_ready = 1'b0;
        n_cmp++; if (level !== 5'd16) begin n_fail++; $display("FAIL pushpop_level got %0d want 16", level); end
        n_cmp++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL pushpop_drops got %0d want 0", drop_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pushpop_ovf got %b want 0", overflow); end
        for (int e = 1; e < 16; e++) begin
            read_entry(w0, w1, w2, w3, ok);
            n_cmp++; if (!ok || w0 !== exp_pc[e] || w1 !== exp_inst[e]) begin
                n_fail++; $display("FAIL drain_e%0d got %h/%h want %h/%h", e, w0, w1, exp_pc[e], exp_inst[e]);
            end
        end
        read_entry(w0, w1, w2, w3, ok);
        n_cmp++; if (!ok || w0 !== new_pc || w1 !== new_inst) begin
            n_fail++; $display("FAIL drain_new got %h/%h want %h/%h", w0, w1, new_pc, new_inst);
        end
        n_cmp++; if (level !== 5'd0) begin n_fail++; $display("FAIL drain_level got %0d want 0", level); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_q [$];
        logic [31:0] held;
        bit hold_v = 1'b0;
        int got = 0;
        int guard = 0;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(cur_pc);
            exp_q.push_back(cur_inst);
            exp_q.push_back(32'd0);
            exp_q.push_back(32'd0);
            retire_to(32'h00006000 + 32'(4 * i), 32'hC0000000 + 32'(i));
        end
        n_cmp++; if (level !== 5'd6) begin n_fail++; $display("FAIL bp_level got %0d want 6", level); end
        held = 32'd0;
        while (got < 24 && guard < 400) begin
            if (hold_v) begin
                n_cmp++; if (sif.out_data !== held) begin n_fail++; $display("FAIL bp_stable got %h want %h", sif.out_data, held); end
            end
            sif.out_ready = 1'($urandom_range(0, 1));
            if (sif.out_valid) begin
                if (sif.out_ready) begin
                    n_cmp++; if (sif.out_data !== exp_q[got]) begin n_fail++; $display("FAIL bp_word%0d got %h want %h", got, sif.out_data, exp_q[got]); end
                    got++;
                    hold_v = 1'b0;
                end else begin
                    held   = sif.out_data;
                    hold_v = 1'b1;
                end
            end
            tick();
            guard++;
        end
        sif.out_ready = 1'b0;
        n_cmp++; if (got != 24) begin n_fail++; $display("FAIL bp_count got %0d want 24", got); end
        n_cmp++; if (level !== 5'd0) begin n_fail++; $display("FAIL bp_level0 got %0d want 0", level); end
    endtask

    task automatic test_trace_en();
        logic [31:0] w0, w1, w2, w3;
        bit ok;
        trace_en = 1'b0;
        retire_to(32'h00007100, 32'hE0000000);
        n_cmp++; if (level !== 5'd0) begin n_fail++; $display("FAIL en_off_level got %0d want 0", level); end
        trace_en = 1'b1;
        retire_to(32'h00007200, 32'hE0000001);
        n_cmp++; if (sif.out_data !== 32'h00007100) begin n_fail++; $display("FAIL en_on_w0 got %h want 00007100", sif.out_data); end
        read_entry(w0, w1, w2, w3, ok);
        n_cmp++; if (!ok || w1 !== 32'hE0000000) begin n_fail++; $display("FAIL en_on_w1 got %h want e0000000", w1); end
    endtask

    task automatic test_reset_mid_stream();
        logic [31:0] w0, w1, w2, w3;
        bit ok;
        retire_to(32'h00007300, 32'hE0000002);
        sif.out_ready = 1'b1;
        tick(); tick();
        sif.out_ready = 1'b0;
        n_cmp++; if (sif.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pending got %b want 1", sif.out_valid); end
        reset = 1'b0;
        #1;
        n_cmp++; if (sif.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid got %b want 0", sif.out_valid); end
        n_cmp++; if (level !== 5'd0) begin n_fail++; $display("FAIL mid_async_level got %0d want 0", level); end
        tick(); tick();
        pc = 32'h00005000; inst = 32'hD0000000;
        reset = 1'b1;
        tick();
        cur_pc = pc; cur_inst = inst;
        retire_to(32'h00005004, 32'hD0000001);
        n_cmp++; if (sif.out_data !== 32'h00005000) begin n_fail++; $display("FAIL mid_w0 got %h want 00005000", sif.out_data); end
        read_entry(w0, w1, w2, w3, ok);
        n_cmp++; if (!ok || w1 !== 32'hD0000000) begin n_fail++; $display("FAIL mid_w1 got %h want d0000000", w1); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_write();
        test_last_write_wins();
        test_overflow();
        test_backpressure();
        test_trace_en();
        test_reset_mid_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end
endmodule
